// File: rtl/ax_region_timer_pkg.sv
// Shared fetch-unit types for the approximate-region timer: channel index,
// per-channel FSM state, close result record and default configuration.
package FetchUnitTypes;

   localparam int AX_REGION_CH_NUM    = 4;
   localparam int AX_REGION_TIMEOUT   = 4096;
   localparam int AX_REGION_CNT_WIDTH = 32;

   // A single channel still needs a one-bit index so lane buses stay non-empty.
   function automatic int ch_index_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   localparam int AX_REGION_CH_W = ch_index_width(AX_REGION_CH_NUM);

   typedef logic [AX_REGION_CH_W-1:0] RegionChIndex;

   typedef enum logic {
      RT_IDLE    = 1'b0,
      RT_RUNNING = 1'b1
   } RegionTimerState;

   typedef struct packed {
      logic                           done;
      logic                           timedOut;
      logic [AX_REGION_CNT_WIDTH-1:0] elapsed;
   } RegionTimerResult;

endpackage

// File: rtl/ax_region_timer_channel.sv
// One region channel: IDLE/RUNNING FSM, begin-cycle register, elapsed and
// timeout evaluation. Optional statistics under AX_REGION_TIMER_STATS_EN.
module ax_region_timer_channel
   import FetchUnitTypes::*;
#(
   parameter int CNT_WIDTH = AX_REGION_CNT_WIDTH,
   parameter int TIMEOUT   = AX_REGION_TIMEOUT
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [CNT_WIDTH-1:0] cyclecounter_i,
   input  logic                 flush_i,
   input  logic                 start_hit_i,
   input  logic                 end_hit_i,
   output RegionTimerState      state_o,
   output logic [CNT_WIDTH-1:0] begin_o,
   output logic                 done_o,
   output logic                 timed_out_o,
   output logic [CNT_WIDTH-1:0] elapsed_o
`ifdef AX_REGION_TIMER_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0] close_count_o,
   output logic [CNT_WIDTH-1:0] max_elapsed_o
`endif
);

   localparam logic [CNT_WIDTH-1:0] TIMEOUT_V = CNT_WIDTH'(TIMEOUT);
   localparam bit                   TO_EN     = (TIMEOUT != 0);

   RegionTimerState      state_q, state_d;
   logic [CNT_WIDTH-1:0] begin_q, begin_d;
   logic                 done_q, done_d;
   logic                 timed_out_q, timed_out_d;
   logic [CNT_WIDTH-1:0] elapsed_q, elapsed_d;
   logic [CNT_WIDTH-1:0] diff;
   logic                 to_hit;

   // Modulo subtraction makes a counter wrap inside an interval harmless.
   assign diff   = cyclecounter_i - begin_q;
   assign to_hit = TO_EN && (state_q == RT_RUNNING) && (diff >= TIMEOUT_V) && !end_hit_i;

   always_comb begin
      state_d     = state_q;
      begin_d     = begin_q;
      done_d      = 1'b0;
      timed_out_d = 1'b0;
      elapsed_d   = elapsed_q;
      if (flush_i) begin
         state_d = RT_IDLE;
      end else begin
         unique case (state_q)
            RT_IDLE: begin
               if (start_hit_i) begin
                  state_d = RT_RUNNING;
                  begin_d = cyclecounter_i;
               end
            end
            RT_RUNNING: begin
               if (end_hit_i) begin
                  done_d    = 1'b1;
                  elapsed_d = diff;
                  state_d   = RT_IDLE;
               end else if (to_hit) begin
                  done_d      = 1'b1;
                  timed_out_d = 1'b1;
                  elapsed_d   = TIMEOUT_V;
                  state_d     = RT_IDLE;
               end
               // A start in the same cycle reopens immediately after any close.
               if (start_hit_i) begin
                  state_d = RT_RUNNING;
                  begin_d = cyclecounter_i;
               end
            end
            default: state_d = RT_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= RT_IDLE;
         begin_q     <= '0;
         done_q      <= 1'b0;
         timed_out_q <= 1'b0;
         elapsed_q   <= '0;
      end else begin
         state_q     <= state_d;
         begin_q     <= begin_d;
         done_q      <= done_d;
         timed_out_q <= timed_out_d;
         elapsed_q   <= elapsed_d;
      end
   end

   assign state_o     = state_q;
   assign begin_o     = begin_q;
   assign done_o      = done_q;
   assign timed_out_o = timed_out_q;
   assign elapsed_o   = elapsed_q;

`ifdef AX_REGION_TIMER_STATS_EN
   logic [CNT_WIDTH-1:0] close_count_q, close_count_d;
   logic [CNT_WIDTH-1:0] max_elapsed_q, max_elapsed_d;

   always_comb begin
      close_count_d = close_count_q;
      max_elapsed_d = max_elapsed_q;
      if (done_d) begin
         if (close_count_q != '1) close_count_d = close_count_q + 1'b1;
         if (elapsed_d > max_elapsed_q) max_elapsed_d = elapsed_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         close_count_q <= '0;
         max_elapsed_q <= '0;
      end else begin
         close_count_q <= close_count_d;
         max_elapsed_q <= max_elapsed_d;
      end
   end

   assign close_count_o = close_count_q;
   assign max_elapsed_o = max_elapsed_q;
`endif

endmodule

// File: rtl/ax_region_timer.sv
// Multi-channel approximate-region timer: decodes start/end lanes into
// per-channel hits and instantiates one channel per region. Optional
// closeCount/maxElapsed outputs under AX_REGION_TIMER_STATS_EN.
module ax_region_timer
   import FetchUnitTypes::*;
#(
   parameter int NUM_CH      = AX_REGION_CH_NUM,
   parameter int CNT_WIDTH   = AX_REGION_CNT_WIDTH,
   parameter int START_LANES = 2,
   parameter int END_LANES   = 2,
   parameter int TIMEOUT     = AX_REGION_TIMEOUT,
   localparam int CH_W       = ch_index_width(NUM_CH)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [CNT_WIDTH-1:0]                 cyclecounter,
   input  logic                                 flush,
   input  logic [START_LANES-1:0]               startValid,
   input  logic [START_LANES-1:0][CH_W-1:0]     startCh,
   input  logic [END_LANES-1:0]                 endValid,
   input  logic [END_LANES-1:0][CH_W-1:0]       endCh,
   output logic [NUM_CH-1:0]                    busy,
   output logic [NUM_CH-1:0][CNT_WIDTH-1:0]     begincycle,
   output logic [NUM_CH-1:0]                    done,
   output logic [NUM_CH-1:0]                    timedOut,
   output logic [NUM_CH-1:0][CNT_WIDTH-1:0]     elapsed
`ifdef AX_REGION_TIMER_STATS_EN
   ,
   output logic [NUM_CH-1:0][CNT_WIDTH-1:0]     closeCount,
   output logic [NUM_CH-1:0][CNT_WIDTH-1:0]     maxElapsed
`endif
);

   logic [NUM_CH-1:0] start_hit;
   logic [NUM_CH-1:0] end_hit;
   RegionTimerState   ch_state [NUM_CH];

   // Several lanes naming the same channel collapse into a single hit.
   always_comb begin
      start_hit = '0;
      end_hit   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int l = 0; l < START_LANES; l++) begin
            if (startValid[l] && (startCh[l] == CH_W'(c))) start_hit[c] = 1'b1;
         end
         for (int l = 0; l < END_LANES; l++) begin
            if (endValid[l] && (endCh[l] == CH_W'(c))) end_hit[c] = 1'b1;
         end
      end
   end

   always_comb begin
      busy = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         busy[c] = (ch_state[c] == RT_RUNNING);
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      ax_region_timer_channel #(
         .CNT_WIDTH (CNT_WIDTH),
         .TIMEOUT   (TIMEOUT)
      ) u_ch (
         .clk_i          (clk),
         .rst_ni         (rst),
         .cyclecounter_i (cyclecounter),
         .flush_i        (flush),
         .start_hit_i    (start_hit[c]),
         .end_hit_i      (end_hit[c]),
         .state_o        (ch_state[c]),
         .begin_o        (begincycle[c]),
         .done_o         (done[c]),
         .timed_out_o    (timedOut[c]),
         .elapsed_o      (elapsed[c])
`ifdef AX_REGION_TIMER_STATS_EN
         ,
         .close_count_o  (closeCount[c]),
         .max_elapsed_o  (maxElapsed[c])
`endif
      );
   end

endmodule

// File: tb/tb_ax_region_timer.sv
// Directed bench for ax_region_timer: drivers push expected closes into a
// queue, a negedge monitor pops them whenever a done pulse appears.
module tb_ax_region_timer;

   localparam int NCH = 4;
   localparam int CW  = 32;
   localparam int SL  = 2;
   localparam int EL  = 2;
   localparam int TO  = 40;
   localparam int EW  = 2 + 1 + CW;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [CW-1:0]           cc;
   logic                    flush;
   logic [SL-1:0]           startValid;
   logic [SL-1:0][1:0]      startCh;
   logic [EL-1:0]           endValid;
   logic [EL-1:0][1:0]      endCh;
   logic [NCH-1:0]          busy;
   logic [NCH-1:0][CW-1:0]  begincycle;
   logic [NCH-1:0]          done;
   logic [NCH-1:0]          timedOut;
   logic [NCH-1:0][CW-1:0]  elapsed;
`ifdef AX_REGION_TIMER_STATS_EN
   logic [NCH-1:0][CW-1:0]  closeCount;
   logic [NCH-1:0][CW-1:0]  maxElapsed;
`endif

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];

   ax_region_timer #(
      .NUM_CH(NCH), .CNT_WIDTH(CW), .START_LANES(SL), .END_LANES(EL), .TIMEOUT(TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cyclecounter (cc),
      .flush        (flush),
      .startValid   (startValid),
      .startCh      (startCh),
      .endValid     (endValid),
      .endCh        (endCh),
      .busy         (busy),
      .begincycle   (begincycle),
      .done         (done),
      .timedOut     (timedOut),
      .elapsed      (elapsed)
`ifdef AX_REGION_TIMER_STATS_EN
      ,
      .closeCount   (closeCount),
      .maxElapsed   (maxElapsed)
`endif
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // check helpers
   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_close(input int ch, input logic to, input logic [CW-1:0] el);
      exp_q.push_back({2'(ch), to, el});
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
      cc         = cc + 1;
      startValid = '0;
      endValid   = '0;
      flush      = 1'b0;
   endtask

   task automatic run_to(input logic [CW-1:0] target);
      int guard = 0;
      while (cc != target && guard < 2000) begin
         tick();
         guard++;
      end
      chk("run_to_reached", cc, target);
   endtask

   task automatic start_ev(input int lane, input int ch);
      startValid[lane] = 1'b1;
      startCh[lane]    = 2'(ch);
   endtask

   task automatic end_ev(input int lane, input int ch);
      endValid[lane] = 1'b1;
      endCh[lane]    = 2'(ch);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            if (done[c]) begin
               logic [EW-1:0] got;
               logic [EW-1:0] exp;
               got = {2'(c), timedOut[c], elapsed[c]};
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_done: ch=%0d timedOut=%0b elapsed=0x%0h, none expected",
                           c, timedOut[c], elapsed[c]);
               end else begin
                  exp = exp_q.pop_front();
                  if (got !== exp) begin
                     errors++;
                     $display("FAIL close_result: got {ch,to,el}=0x%0h expected 0x%0h", got, exp);
                  end
               end
            end
         end
      end
   end

   // stimulus
   initial begin
      rst        = 1'b0;
      cc         = '0;
      flush      = 1'b0;
      startValid = '0;
      startCh    = '0;
      endValid   = '0;
      endCh      = '0;
      #2;
      chk("rst_busy", CW'(busy), 0);
      chk("rst_done", CW'(done), 0);
      chk("rst_timedOut", CW'(timedOut), 0);
      chk("rst_begincycle1", begincycle[1], 0);
      chk("rst_elapsed1", elapsed[1], 0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // basic interval on ch1
      cc = 100; start_ev(0, 1); tick();
      chk("t1_busy1", CW'(busy[1]), 1);
      chk("t1_begin1", begincycle[1], 100);
      run_to(130);
      end_ev(1, 1); expect_close(1, 1'b0, 30); tick();
      chk("t1_done1", CW'(done[1]), 1);
      chk("t1_timedOut1", CW'(timedOut[1]), 0);
      chk("t1_elapsed1", elapsed[1], 30);
      chk("t1_busy1_after", CW'(busy[1]), 0);
      tick();
      chk("t1_done_clears", CW'(done), 0);
      chk("t1_elapsed_holds", elapsed[1], 30);

      // counter wrap on ch0
      cc = 32'hFFFF_FFF0; start_ev(0, 0); tick();
      chk("t2_begin0", begincycle[0], 32'hFFFF_FFF0);
      cc = 32'h0000_0010; end_ev(0, 0); expect_close(0, 1'b0, 32'h20); tick();
      chk("t2_elapsed0", elapsed[0], 32'h20);

      // restart on ch2
      cc = 50; start_ev(0, 2); tick();
      run_to(60);
      start_ev(1, 2); tick();
      chk("t3_restart_begin2", begincycle[2], 60);
      chk("t3_restart_busy2", CW'(busy[2]), 1);
      run_to(75);
      end_ev(0, 2); expect_close(2, 1'b0, 15); tick();
      chk("t3_elapsed2", elapsed[2], 15);
      chk("t3_busy2", CW'(busy[2]), 0);

      // same-cycle start+end on running ch3
      cc = 70; start_ev(1, 3); tick();
      run_to(80);
      start_ev(0, 3); end_ev(1, 3); expect_close(3, 1'b0, 10); tick();
      chk("t3_same_busy3", CW'(busy[3]), 1);
      chk("t3_same_begin3", begincycle[3], 80);
      chk("t3_same_elapsed3", elapsed[3], 10);
      run_to(85);
      end_ev(0, 3); expect_close(3, 1'b0, 5); tick();

      // both lanes hit ch1, then end on idle ch1
      cc = 90; start_ev(0, 1); start_ev(1, 1); tick();
      chk("t3_dual_begin1", begincycle[1], 90);
      run_to(92);
      end_ev(0, 1); end_ev(1, 1); expect_close(1, 1'b0, 2); tick();
      end_ev(0, 1); tick();
      chk("t3_idle_end_busy", CW'(busy), 0);
      chk("t3_idle_end_done", CW'(done), 0);

      // start+end same cycle on idle ch0 only opens
      cc = 95; start_ev(0, 0); end_ev(1, 0); tick();
      chk("t3_idle_se_busy0", CW'(busy[0]), 1);
      chk("t3_idle_se_begin0", begincycle[0], 95);
      run_to(97);
      end_ev(0, 0); expect_close(0, 1'b0, 2); tick();

      // timeout on ch0, later end ignored
      cc = 200; start_ev(0, 0); tick();
      run_to(240);
      expect_close(0, 1'b1, TO); tick();
      chk("t4_done0", CW'(done[0]), 1);
      chk("t4_timedOut0", CW'(timedOut[0]), 1);
      chk("t4_elapsed0", elapsed[0], TO);
      chk("t4_busy0", CW'(busy[0]), 0);
      end_ev(0, 0); tick();
      chk("t4_late_end_done", CW'(done), 0);

      // end wins over timeout in the same cycle
      cc = 400; start_ev(1, 1); tick();
      run_to(440);
      end_ev(1, 1); expect_close(1, 1'b0, TO); tick();
      chk("t4_endwins_timedOut1", CW'(timedOut[1]), 0);

      // flush with ch0/ch1 running and a start on ch2
      cc = 500; start_ev(0, 0); start_ev(1, 1); tick();
      chk("t5_busy_pre", CW'(busy), 32'h3);
      run_to(505);
      flush = 1'b1; start_ev(0, 2); end_ev(0, 0); tick();
      chk("t5_busy_post", CW'(busy), 0);
      chk("t5_done_post", CW'(done), 0);
      chk("t5_begin2_kept", begincycle[2], 60);
      chk("t5_begin0_kept", begincycle[0], 500);

      // async reset mid-interval
      cc = 600; start_ev(0, 3); tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("t6_rst_busy", CW'(busy), 0);
      chk("t6_rst_begin3", begincycle[3], 0);
      chk("t6_rst_elapsed0", elapsed[0], 0);
      #1;
      rst = 1'b1;
      tick();

      // three intervals on ch1: 5, 12, 7
      cc = 700; start_ev(0, 1); tick();
      run_to(705); end_ev(0, 1); expect_close(1, 1'b0, 5); tick();
      cc = 710; start_ev(0, 1); tick();
      run_to(722); end_ev(0, 1); expect_close(1, 1'b0, 12); tick();
      cc = 730; start_ev(0, 1); tick();
      run_to(737); end_ev(0, 1); expect_close(1, 1'b0, 7); tick();
      chk("t7_elapsed1", elapsed[1], 7);
`ifdef AX_REGION_TIMER_STATS_EN
      chk("t7_closeCount1", closeCount[1], 3);
      chk("t7_maxElapsed1", maxElapsed[1], 12);
      chk("t7_closeCount0", closeCount[0], 0);
`endif

      tick();
      tick();
      chk("queue_empty", CW'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ax_region_timer.md
Name: ax_region_timer

Overview:
- Multi-channel successor to the single begin-cycle latch in the fetch unit.
- Tracks up to NUM_CH concurrent approximate regions. Each region:
  - opens on a fetch-buffer hit (start event);
  - closes on a resolved approximate branch (end event), a timeout, or a flush.
- On close, reports the elapsed cycle count per channel. Sits beside NextPC/Fetch stages; fed by the global cycle counter.

Parameters:
- NUM_CH, 4, number of independent region channels (>=1).
- CNT_WIDTH, 32, width of cycle counter, begin-cycle and elapsed values.
- START_LANES, 2, number of start-event lanes (FETCH_WIDTH in the core).
- END_LANES, 2, number of end-event lanes (INT_ISSUE_WIDTH in the core).
- TIMEOUT, 4096, elapsed value that forces close; 0 disables timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cyclecounter  in  CNT_WIDTH  free-running cycle counter.
- flush  in  1  pipeline flush; closes all channels silently.
- startValid  in  START_LANES  start event per lane.
- startCh  in  START_LANES x clog2(NUM_CH)  target channel per start lane.
- endValid  in  END_LANES  end event per lane (isApBCC && !bufHit).
- endCh  in  END_LANES x clog2(NUM_CH)  target channel per end lane.
- busy  out  NUM_CH  channel RUNNING.
- begincycle  out  NUM_CH x CNT_WIDTH  captured start cycle per channel.
- done  out  NUM_CH  one-cycle close pulse per channel.
- timedOut  out  NUM_CH  qualifies done: close caused by timeout.
- elapsed  out  NUM_CH x CNT_WIDTH  interval length, valid while done=1.

Behaviour:
- Reset (rst=0, async): all channels IDLE; busy, begincycle, done, timedOut, elapsed all 0.
- Per-channel FSM, two states:
  - IDLE -> RUNNING on any start hit.
  - RUNNING -> IDLE on end, timeout or flush.
- Event hits, evaluated per channel from the current-cycle inputs:
  - start hit = any lane with startValid[i] && startCh[i]==ch.
  - end hit = any lane with endValid[j] && endCh[j]==ch.
- Start capture: begincycle <= cyclecounter at the edge ending the hit cycle. Multiple lanes hitting the same channel produce a single capture.
- Start while RUNNING (no end in the same cycle): restart. Re-capture begincycle, stay RUNNING, no done pulse.
- End while RUNNING:
  - elapsed <= cyclecounter - begincycle, modulo 2^CNT_WIDTH, so counter wrap is handled naturally.
  - done=1, timedOut=0 on the next cycle (1-cycle latency); channel goes IDLE.
- End while IDLE: ignored, no pulse.
- Start and end on the same channel in the same cycle, channel RUNNING:
  - the old interval closes (done pulse, elapsed against the old begincycle);
  - the new interval opens with begincycle <= cyclecounter; channel stays RUNNING.
- Start and end on the same channel in the same cycle, channel IDLE: opens only.
- Timeout (TIMEOUT != 0): while RUNNING and (cyclecounter - begincycle) >= TIMEOUT with no end hit, close with done=1, timedOut=1, elapsed=TIMEOUT. An end hit in the same cycle wins, so timedOut=0.
- flush:
  - highest priority; all channels go IDLE, no done pulses;
  - starts in the same cycle are dropped;
  - begincycle keeps its last value.
- done, timedOut and elapsed are registered; done and timedOut clear the following cycle unless a new close occurs. elapsed holds its last value.
- Channels are fully independent; any mix of channels may close in the same cycle.

Optional Feature:
- AX_REGION_TIMER_STATS_EN.
- When defined, adds per-channel outputs:
  - closeCount (CNT_WIDTH): increments on every done, saturates at all-ones;
  - maxElapsed (CNT_WIDTH): running maximum of elapsed.
- Both reset to 0 and are unaffected by flush.
- When not defined, these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package (FetchUnitTypes):
  - typedef RegionChIndex (clog2(NUM_CH) bits);
  - typedef RegionTimerState enum {RT_IDLE, RT_RUNNING};
  - typedef RegionTimerResult struct {done, timedOut, elapsed};
  - constants AX_REGION_CH_NUM and AX_REGION_TIMEOUT.
- One sub-module: ax_region_timer_channel, holding the single-channel FSM, begin register and elapsed/timeout logic. Instantiate NUM_CH times; the top level only decodes lane hits per channel.

Test Plan:
- Reset, then start ch1 at cyclecounter=100, end ch1 at 130 -> next cycle done[1]=1, timedOut=0, elapsed[1]=30, busy[1]=0.
- Wrap: start ch0 at 0xFFFF_FFF0, end at 0x0000_0010 -> elapsed[0]=0x20.
- Restart: start ch2 at 50, start ch2 again at 60, end at 75 -> exactly one done, elapsed=15. Same-cycle start+end at 80 on running ch3 begun at 70 -> done elapsed=10, busy stays 1, begincycle=80.
- Timeout: TIMEOUT=8, start ch0 at 200, no end -> close at counter 208: done=1, timedOut=1, elapsed=8. A later end on ch0 is ignored.
- Flush at 300 with ch0/ch1 running and a start on ch2 -> all busy=0, no done pulses, begincycle[2] unchanged. Async rst mid-interval -> outputs 0 immediately.
- With AX_REGION_TIMER_STATS_EN: three intervals on ch1 of 5, 12, 7 -> closeCount=3, maxElapsed=12.
